// File: rtl/uivtc_mw.sv
// Multi-window video timing generator: HS/VS/DE, pixel coordinates, frame-start pulse and
// NUM_WIN overlay-window DE strobes with per-frame shadowed window configuration.
module uivtc_mw #(
    parameter int CNT_W        = 12,
    parameter int NUM_WIN      = 2,
    parameter int H_ActiveSize = 1024,
    parameter int H_FrameSize  = 1344,
    parameter int H_SyncStart  = 1164,
    parameter int H_SyncEnd    = 1184,
    parameter int V_ActiveSize = 600,
    parameter int V_FrameSize  = 635,
    parameter int V_SyncStart  = 620,
    parameter int V_SyncEnd    = 623,
    parameter bit HS_POL       = 1'b1,
    parameter bit VS_POL       = 1'b1
) (
    input  logic                     I_vtc_clk,
    input  logic                     I_vtc_rst,
    input  logic                     I_vtc_en,
    input  logic [NUM_WIN*CNT_W-1:0] I_win_x,
    input  logic [NUM_WIN*CNT_W-1:0] I_win_y,
    input  logic [NUM_WIN*CNT_W-1:0] I_win_w,
    input  logic [NUM_WIN*CNT_W-1:0] I_win_h,
    output logic                     O_vtc_hs,
    output logic                     O_vtc_vs,
    output logic                     O_vtc_de,
    output logic [CNT_W-1:0]         O_vtc_x,
    output logic [CNT_W-1:0]         O_vtc_y,
    output logic                     O_vtc_fs,
    output logic [NUM_WIN-1:0]       O_win_de,
    output logic                     O_vtc_busy
);

    // state | meaning
    // IDLE  | counters held at 0, outputs at inactive levels
    // RUN   | generating timing, window shadow reloads at each frame end
    // STOP  | finishing the current frame, then IDLE (RUN again if re-enabled)
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         hcnt, vcnt;
    logic [NUM_WIN*CNT_W-1:0] sh_x, sh_y, sh_w, sh_h;
    logic                     active, last_px, h_last, shadow_load;
    logic                     hs_c, vs_c, de_c;
    logic [NUM_WIN-1:0]       win_c;

    assign active  = (state != IDLE);
    assign h_last  = (hcnt == CNT_W'(H_FrameSize - 1));
    assign last_px = h_last && (vcnt == CNT_W'(V_FrameSize - 1));

    always_comb begin
        state_nxt   = state;
        shadow_load = 1'b0;
        case (state)
            IDLE: begin
                if (I_vtc_en) begin
                    state_nxt   = RUN;
                    shadow_load = 1'b1;
                end
            end
            RUN: begin
                shadow_load = last_px;
                if (!I_vtc_en) state_nxt = STOP;
            end
            STOP: begin
                if (I_vtc_en)     state_nxt = RUN;
                else if (last_px) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hs_c = (hcnt >= CNT_W'(H_SyncStart)) && (hcnt < CNT_W'(H_SyncEnd));
    assign vs_c = (vcnt >= CNT_W'(V_SyncStart)) && (vcnt < CNT_W'(V_SyncEnd));
    assign de_c = (hcnt < CNT_W'(H_ActiveSize)) && (vcnt < CNT_W'(V_ActiveSize));

    // Window edges are extended by one bit so x+w / y+h cannot wrap.
    for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
        logic [CNT_W:0] x_lo, x_hi, y_lo, y_hi, hc, vc;
        assign x_lo     = {1'b0, sh_x[g*CNT_W +: CNT_W]};
        assign y_lo     = {1'b0, sh_y[g*CNT_W +: CNT_W]};
        assign x_hi     = x_lo + {1'b0, sh_w[g*CNT_W +: CNT_W]};
        assign y_hi     = y_lo + {1'b0, sh_h[g*CNT_W +: CNT_W]};
        assign hc       = {1'b0, hcnt};
        assign vc       = {1'b0, vcnt};
        assign win_c[g] = de_c && (hc >= x_lo) && (hc < x_hi) && (vc >= y_lo) && (vc < y_hi);
    end

    always_ff @(posedge I_vtc_clk) begin
        if (I_vtc_rst) begin
            state      <= IDLE;
            hcnt       <= '0;
            vcnt       <= '0;
            sh_x       <= '0;
            sh_y       <= '0;
            sh_w       <= '0;
            sh_h       <= '0;
            O_vtc_hs   <= ~HS_POL;
            O_vtc_vs   <= ~VS_POL;
            O_vtc_de   <= 1'b0;
            O_vtc_x    <= '0;
            O_vtc_y    <= '0;
            O_vtc_fs   <= 1'b0;
            O_win_de   <= '0;
            O_vtc_busy <= 1'b0;
        end else begin
            state <= state_nxt;
            if (shadow_load) begin
                sh_x <= I_win_x;
                sh_y <= I_win_y;
                sh_w <= I_win_w;
                sh_h <= I_win_h;
            end
            if (active) begin
                hcnt <= h_last ? '0 : hcnt + 1'b1;
                if (h_last) vcnt <= last_px ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= '0;
                vcnt <= '0;
            end
            // Outputs carry the decode of the counters as they were before this edge.
            if (active) begin
                O_vtc_hs   <= hs_c ? HS_POL : ~HS_POL;
                O_vtc_vs   <= vs_c ? VS_POL : ~VS_POL;
                O_vtc_de   <= de_c;
                O_vtc_x    <= hcnt;
                O_vtc_y    <= vcnt;
                O_vtc_fs   <= (hcnt == '0) && (vcnt == '0);
                O_win_de   <= win_c;
                O_vtc_busy <= 1'b1;
            end else begin
                O_vtc_hs   <= ~HS_POL;
                O_vtc_vs   <= ~VS_POL;
                O_vtc_de   <= 1'b0;
                O_vtc_x    <= '0;
                O_vtc_y    <= '0;
                O_vtc_fs   <= 1'b0;
                O_win_de   <= '0;
                O_vtc_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uivtc_mw.sv
// Scoreboard bench for uivtc_mw: a frame-position reference model pushes expected outputs,
// a negedge monitor pops and compares against an active-high and an active-low instance.
module tb_uivtc_mw;

    localparam int CW = 4;
    localparam int NW = 2;
    localparam int HA = 8, HF = 12, HSS = 9, HSE = 10;
    localparam int VA = 4, VF = 6, VSS = 4, VSE = 5;
    localparam int FR = HF * VF;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic          fs;
        logic          busy;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [NW-1:0] win;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en;
    logic [NW*CW-1:0] win_x, win_y, win_w, win_h;

    logic          hs1, vs1, de1, fs1, busy1;
    logic [CW-1:0] x1, y1;
    logic [NW-1:0] wd1;
    logic          hs0, vs0, de0, fs0, busy0;
    logic [CW-1:0] x0, y0;
    logic [NW-1:0] wd0;

    uivtc_mw #(.CNT_W(CW), .NUM_WIN(NW), .H_ActiveSize(HA), .H_FrameSize(HF),
               .H_SyncStart(HSS), .H_SyncEnd(HSE), .V_ActiveSize(VA), .V_FrameSize(VF),
               .V_SyncStart(VSS), .V_SyncEnd(VSE), .HS_POL(1'b1), .VS_POL(1'b1)) dut_hi (
        .I_vtc_clk(clk), .I_vtc_rst(rst), .I_vtc_en(en),
        .I_win_x(win_x), .I_win_y(win_y), .I_win_w(win_w), .I_win_h(win_h),
        .O_vtc_hs(hs1), .O_vtc_vs(vs1), .O_vtc_de(de1), .O_vtc_x(x1), .O_vtc_y(y1),
        .O_vtc_fs(fs1), .O_win_de(wd1), .O_vtc_busy(busy1));

    uivtc_mw #(.CNT_W(CW), .NUM_WIN(NW), .H_ActiveSize(HA), .H_FrameSize(HF),
               .H_SyncStart(HSS), .H_SyncEnd(HSE), .V_ActiveSize(VA), .V_FrameSize(VF),
               .V_SyncStart(VSS), .V_SyncEnd(VSE), .HS_POL(1'b0), .VS_POL(1'b0)) dut_lo (
        .I_vtc_clk(clk), .I_vtc_rst(rst), .I_vtc_en(en),
        .I_win_x(win_x), .I_win_y(win_y), .I_win_w(win_w), .I_win_h(win_h),
        .O_vtc_hs(hs0), .O_vtc_vs(vs0), .O_vtc_de(de0), .O_vtc_x(x0), .O_vtc_y(y0),
        .O_vtc_fs(fs0), .O_win_de(wd0), .O_vtc_busy(busy0));

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    bit   mon_en = 1'b0;

    // Reference model: mode 0 idle, 1 running, 2 finishing frame; pos = y*HF + x.
    int mode = 0;
    int pos  = 0;
    int shx[NW], shy[NW], shw[NW], shh[NW];

    function automatic exp_t decode(int p);
        exp_t e;
        int   x, y;
        x      = p % HF;
        y      = p / HF;
        e.hs   = (x >= HSS && x < HSE);
        e.vs   = (y >= VSS && y < VSE);
        e.de   = (x < HA && y < VA);
        e.fs   = (p == 0);
        e.busy = 1'b1;
        e.x    = CW'(x);
        e.y    = CW'(y);
        for (int i = 0; i < NW; i++)
            e.win[i] = e.de && x >= shx[i] && x < shx[i] + shw[i]
                            && y >= shy[i] && y < shy[i] + shh[i];
        return e;
    endfunction

    task automatic step();
        exp_t e;
        bit   last, load;
        @(posedge clk);
        e = '0;
        if (rst) begin
            mode = 0;
            pos  = 0;
            for (int i = 0; i < NW; i++) begin
                shx[i] = 0; shy[i] = 0; shw[i] = 0; shh[i] = 0;
            end
        end else begin
            if (mode != 0) e = decode(pos);
            last = (pos == FR - 1);
            load = (mode == 0 && en) || (mode == 1 && last);
            if (load)
                for (int i = 0; i < NW; i++) begin
                    shx[i] = int'(win_x[i*CW +: CW]);
                    shy[i] = int'(win_y[i*CW +: CW]);
                    shw[i] = int'(win_w[i*CW +: CW]);
                    shh[i] = int'(win_h[i*CW +: CW]);
                end
            pos = (mode == 0) ? 0 : (pos + 1) % FR;
            case (mode)
                0:       mode = en ? 1 : 0;
                1:       mode = en ? 1 : 2;
                default: mode = en ? 1 : (last ? 0 : 2);
            endcase
        end
        q.push_back(e);
        mon_en = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e, g1, g0;
        if (q.size() > 0) begin
            e  = q.pop_front();
            g1 = {hs1, vs1, de1, fs1, busy1, x1, y1, wd1};
            g0 = {hs0, vs0, de0, fs0, busy0, x0, y0, wd0};
            checks++;
            if (g1 !== e) begin
                fails++;
                $display("FAIL pol_hi outputs at %0t: got %h expected %h", $time, g1, e);
            end
            e.hs = ~e.hs;
            e.vs = ~e.vs;
            checks++;
            if (g0 !== e) begin
                fails++;
                $display("FAIL pol_lo outputs at %0t: got %h expected %h", $time, g0, e);
            end
        end else if (mon_en) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end
    end

    task automatic run_until_pos(int target, string name);
        int n = 0;
        while (pos != target && n < 200) begin
            step();
            n++;
        end
        if (pos != target) begin
            checks++;
            fails++;
            $display("FAIL %s timeout: got pos %0d expected %0d", name, pos, target);
        end
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        en    = 1'b0;
        win_x = '0; win_y = '0; win_w = '0; win_h = '0;
        repeat (3) step();

        // Window 0: x=2,y=1,w=3,h=2; window 1: x=6,y=0,w=5,h=4 (clipped by active area).
        rst   = 1'b0;
        win_x = {4'd6, 4'd2};
        win_y = {4'd0, 4'd1};
        win_w = {4'd5, 4'd3};
        win_h = {4'd4, 4'd2};
        en    = 1'b1;
        repeat (FR + 10) step();
        run_until_pos(2 * HF + 3, "mid_frame");
        win_x[CW-1:0] = 4'd5;
        repeat (50) step();
        run_until_pos(HF, "stop_point");
        en = 1'b0;
        n  = 0;
        while (mode != 0 && n < 200) begin
            step();
            n++;
        end
        repeat (3) step();
        en = 1'b1;
        repeat (FR + 5) step();

        for (int i = 0; i < 1200; i++) begin
            en  = (i % 300 < 90) ? 1'b0 : ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) begin
                win_x = NW*CW'($urandom);
                win_y = NW*CW'($urandom);
                win_w = NW*CW'($urandom);
                win_h = NW*CW'($urandom);
                if ($urandom_range(0, 3) == 0) win_w[CW-1:0] = '0;
            end
            step();
        end
        rst = 1'b0;

        // Reset mid-frame, then a zero-width window 0 that must never assert.
        en = 1'b1;
        repeat (3) step();
        run_until_pos(2 * HF + 4, "reset_point");
        rst = 1'b1;
        step();
        rst   = 1'b0;
        win_x = {4'd1, 4'd0};
        win_y = {4'd0, 4'd0};
        win_w = {4'd4, 4'd0};
        win_h = {4'd3, 4'd6};
        repeat (2 * FR) step();

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
